// File: rtl/lsu_axi.sv
// Load/store unit bridging a simple request port to AXI4 read and write channels.
// Stores drain through a small in-order buffer; a single load may be outstanding.
module lsu_axi #(
    parameter int ADDR_W     = 22,
    parameter int SBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,

    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,

    output logic              sbuf_empty,
    output logic              bus_err,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic [7:0]        awlen,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int PW = (SBUF_DEPTH > 1) ? $clog2(SBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_AR   = 2'd1;
    localparam logic [1:0] L_R    = 2'd2;
    localparam logic [1:0] L_RSP  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_B    = 2'd2;

    logic [1:0]        l_state;
    logic [1:0]        s_state;

    logic [ADDR_W-1:0] fifo_addr [SBUF_DEPTH];
    logic [31:0]       fifo_data [SBUF_DEPTH];
    logic [3:0]        fifo_strb [SBUF_DEPTH];
    logic [1:0]        fifo_size [SBUF_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [1:0]        eff_size;
    logic              misaligned;
    logic              hazard;
    logic [PW-1:0]     slot_off;
    logic [31:0]       st_data;
    logic [3:0]        st_strb;
    logic              accept;
    logic              push;
    logic              pop;
    logic              ld_go;
    logic              mis_go;

    logic [1:0]        ld_off;
    logic [1:0]        ld_size;
    logic              ld_signed;
    logic [4:0]        ld_rd;
    logic [31:0]       ld_shift;
    logic [31:0]       ld_ext;

    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    assign rready     = (l_state == L_R);
    assign bready     = (s_state == S_B);
    assign sbuf_empty = (count == '0) && (s_state == S_IDLE);

    // Size code 11 behaves as a word everywhere except the raw AXI size field.
    assign eff_size   = (req_size == 2'b11) ? 2'b10 : req_size;
    assign misaligned = ((eff_size == 2'b01) && req_addr[0]) ||
                        ((eff_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        st_data = req_wdata;
        st_strb = 4'b1111;
        case (eff_size)
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_strb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_strb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    // A slot is live when its distance from the head is below the count; the
    // head stays live until its write response retires it.
    always_comb begin
        hazard   = 1'b0;
        slot_off = '0;
        for (int i = 0; i < SBUF_DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr;
            if (({1'b0, slot_off} < count) &&
                (fifo_addr[i][ADDR_W-1:2] == req_addr[ADDR_W-1:2]))
                hazard = 1'b1;
        end
    end

    always_comb begin
        if (misaligned)
            req_ready = (l_state == L_IDLE);
        else if (req_we)
            req_ready = (count < CW'(SBUF_DEPTH));
        else
            req_ready = (l_state == L_IDLE) && !hazard;
    end

    assign accept = req_valid && req_ready;
    assign push   = accept && req_we && !misaligned;
    assign ld_go  = accept && !req_we && !misaligned;
    assign mis_go = accept && misaligned;
    assign pop    = (s_state == S_B) && bvalid;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_addr;
            fifo_data[wr_ptr] <= st_data;
            fifo_strb[wr_ptr] <= st_strb;
            fifo_size[wr_ptr] <= req_size;
        end
    end

    // Store side: when idle the AW/W registers load from the head, or straight
    // from the request being pushed so a fresh store issues the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_state <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= 4'b1111;
            bus_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            case (s_state)
                S_IDLE: begin
                    if (count != '0) begin
                        awaddr  <= fifo_addr[rd_ptr];
                        awsize  <= {1'b0, fifo_size[rd_ptr]};
                        wdata   <= fifo_data[rd_ptr];
                        wstrb   <= fifo_strb[rd_ptr];
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        s_state <= S_AW;
                    end else if (push) begin
                        awaddr  <= req_addr;
                        awsize  <= {1'b0, req_size};
                        wdata   <= st_data;
                        wstrb   <= st_strb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        s_state <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready)
                        awvalid <= 1'b0;
                    if (wready)
                        wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready))
                        s_state <= S_B;
                end
                S_B: begin
                    if (bvalid) begin
                        if (bresp != 2'b00)
                            bus_err <= 1'b1;
                        s_state <= S_IDLE;
                    end
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ld_shift = rdata >> {ld_off, 3'b000};
        case (ld_size)
            2'b00:   ld_ext = ld_signed ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                        : {24'd0, ld_shift[7:0]};
            2'b01:   ld_ext = ld_signed ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                        : {16'd0, ld_shift[15:0]};
            default: ld_ext = rdata;
        endcase
    end

    // Load side also owns the response port, including misaligned error replies.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_state    <= L_IDLE;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arsize     <= '0;
            ld_off     <= '0;
            ld_size    <= '0;
            ld_signed  <= 1'b0;
            ld_rd      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (l_state)
                L_IDLE: begin
                    if (mis_go) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                        resp_rd    <= req_rd;
                    end else if (ld_go) begin
                        arvalid   <= 1'b1;
                        araddr    <= req_addr;
                        arsize    <= {1'b0, req_size};
                        ld_off    <= req_addr[1:0];
                        ld_size   <= eff_size;
                        ld_signed <= req_signed;
                        ld_rd     <= req_rd;
                        l_state   <= L_AR;
                    end
                end
                L_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        l_state <= L_R;
                    end
                end
                L_R: begin
                    if (rvalid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= ld_ext;
                        resp_err   <= (rresp != 2'b00);
                        resp_rd    <= ld_rd;
                        l_state    <= L_RSP;
                    end
                end
                default: l_state <= L_IDLE;
            endcase
        end
    end

    logic unused_rlast;
    assign unused_rlast = rlast;

endmodule

// File: tb/tb_lsu_axi.sv
// Directed bench for lsu_axi: hand-driven AXI slave, hand-computed expectations.
module tb_lsu_axi;

    localparam int ADDR_W     = 22;
    localparam int SBUF_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              resp_valid, resp_err, sbuf_empty, bus_err;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic [7:0]        arlen, awlen;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0]       rdata, wdata;
    logic [3:0]        wstrb;

    int checks   = 0;
    int failures = 0;

    lsu_axi #(.ADDR_W(ADDR_W), .SBUF_DEPTH(SBUF_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_err(resp_err), .sbuf_empty(sbuf_empty), .bus_err(bus_err),
        .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] data, input logic [4:0] rd);
        req_valid  = v;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = data;
        req_rd     = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0, 5'd0);
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        nextCycle();
        nextCycle();

        checkOutput("rst_req_ready",  32'(req_ready), 32'd1);
        checkOutput("rst_sbuf_empty", 32'(sbuf_empty), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data",  resp_data, 32'd0);
        checkOutput("rst_resp_rd",    32'(resp_rd), 32'd0);
        checkOutput("rst_resp_err",   32'(resp_err), 32'd0);
        checkOutput("rst_bus_err",    32'(bus_err), 32'd0);
        checkOutput("rst_valids",     32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        checkOutput("rst_wstrb",      32'(wstrb), 32'hF);
        checkOutput("rst_addrs",      32'(araddr) | 32'(awaddr) | wdata, 32'd0);
        checkOutput("const_fields",   {arlen, awlen, 4'd0, arburst, awburst, 7'd0, wlast}, 32'h0000_0501);
        rst = 1'b0;
        nextCycle();

        // Signed byte load from the top lane of the word.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 22'h3, 32'h0, 5'd7);
        checkOutput("lb_ready", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("lb_arvalid", 32'(arvalid), 32'd1);
        checkOutput("lb_araddr",  32'(araddr), 32'h3);
        checkOutput("lb_arsize",  32'(arsize), 32'd0);
        nextCycle();
        checkOutput("lb_rready",     32'(rready), 32'd1);
        checkOutput("lb_arvalid_lo", 32'(arvalid), 32'd0);
        checkOutput("lb_no_early",   32'(resp_valid), 32'd0);
        rvalid = 1'b1; rdata = 32'h80FF_FF12;
        nextCycle();
        rvalid = 1'b0;
        checkOutput("lb_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("lb_resp_data",  resp_data, 32'hFFFF_FF80);
        checkOutput("lb_resp_rd",    32'(resp_rd), 32'd7);
        checkOutput("lb_resp_err",   32'(resp_err), 32'd0);
        nextCycle();
        checkOutput("lb_pulse_end", 32'(resp_valid), 32'd0);

        // Halfword store into the upper half.
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 22'h6, 32'h0000_BEEF, 5'd0);
        checkOutput("sh_ready", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("sh_awvalid", 32'({awvalid, wvalid}), 32'd3);
        checkOutput("sh_awaddr",  32'(awaddr), 32'h6);
        checkOutput("sh_wdata",   wdata, 32'hBEEF_BEEF);
        checkOutput("sh_wstrb",   32'(wstrb), 32'hC);
        checkOutput("sh_awsize",  32'(awsize), 32'd1);
        checkOutput("sh_not_empty", 32'(sbuf_empty), 32'd0);
        nextCycle();
        checkOutput("sh_bready", 32'({bready, awvalid, wvalid}), 32'h4);
        bvalid = 1'b1;
        nextCycle();
        bvalid = 1'b0;
        checkOutput("sh_drained", 32'(sbuf_empty), 32'd1);
        checkOutput("sh_no_err",  32'(bus_err), 32'd0);

        // Load to a buffered word stalls; a load elsewhere bypasses it.
        awready = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 22'h10, 32'h1111_1111, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 22'h10, 32'h0, 5'd2);
        checkOutput("haz_stall_a", 32'(req_ready), 32'd0);
        checkOutput("haz_awvalid", 32'(awvalid), 32'd1);
        nextCycle();
        checkOutput("haz_stall_b", 32'(req_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 22'h20, 32'h0, 5'd3);
        checkOutput("byp_ready", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("byp_arvalid", 32'(arvalid), 32'd1);
        checkOutput("byp_araddr",  32'(araddr), 32'h20);
        nextCycle();
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        nextCycle();
        rvalid = 1'b0;
        checkOutput("byp_resp", resp_data, 32'hCAFE_F00D);
        checkOutput("byp_rd",   32'(resp_rd), 32'd3);
        checkOutput("byp_store_waiting", 32'(awvalid), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 22'h10, 32'h0, 5'd2);
        checkOutput("haz_stall_c", 32'(req_ready), 32'd0);
        awready = 1'b1;
        nextCycle();
        checkOutput("haz_in_b",    32'(bready), 32'd1);
        checkOutput("haz_stall_d", 32'(req_ready), 32'd0);
        bvalid = 1'b1;
        nextCycle();
        bvalid = 1'b0;
        checkOutput("haz_release", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("haz_araddr", 32'(araddr), 32'h10);
        nextCycle();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        nextCycle();
        rvalid = 1'b0;
        checkOutput("haz_resp", {resp_valid, 26'd0, resp_rd}, {1'b1, 26'd0, 5'd2});
        nextCycle();

        // Fill the buffer while the write channel is blocked.
        awready = 1'b0; wready = 1'b0;
        for (int k = 0; k < SBUF_DEPTH; k++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, ADDR_W'(32'h40 + k), 32'(8'hA0 + k), 5'd0);
            checkOutput("fill_ready", 32'(req_ready), 32'd1);
            nextCycle();
            if (k == 0) begin
                checkOutput("fill_awaddr", 32'(awaddr), 32'h40);
                checkOutput("fill_wdata",  wdata, 32'hA0A0_A0A0);
                checkOutput("fill_wstrb",  32'(wstrb), 32'h1);
            end
        end
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 22'h44, 32'hA4, 5'd0);
        checkOutput("full_stall", 32'(req_ready), 32'd0);
        awready = 1'b1; wready = 1'b1;
        nextCycle();
        checkOutput("full_stall_pop", 32'(req_ready), 32'd0);
        bvalid = 1'b1;
        nextCycle();
        checkOutput("full_slot_freed", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("full_issue2_addr", 32'(awaddr), 32'h41);
        checkOutput("full_issue2_strb", 32'(wstrb), 32'h2);
        for (int k = 0; k < 16; k++) nextCycle();
        bvalid = 1'b0;
        checkOutput("full_drained", 32'(sbuf_empty), 32'd1);

        // Misaligned word load: immediate error, nothing on the read channel.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 22'h2, 32'h0, 5'd9);
        checkOutput("mis_ready", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("mis_resp", {resp_valid, resp_err, 25'd0, resp_rd}, {2'b11, 25'd0, 5'd9});
        checkOutput("mis_data", resp_data, 32'd0);
        checkOutput("mis_no_ar", 32'(arvalid), 32'd0);
        nextCycle();
        checkOutput("mis_no_ar2", 32'({arvalid, resp_valid}), 32'd0);

        // Signed halfword load with an error response keeps the extracted value.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 22'h2, 32'h0, 5'd4);
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        rvalid = 1'b1; rdata = 32'h8001_1234; rresp = 2'b10;
        nextCycle();
        rvalid = 1'b0; rresp = 2'b00;
        checkOutput("lh_err",  32'({resp_valid, resp_err}), 32'd3);
        checkOutput("lh_data", resp_data, 32'hFFFF_8001);
        nextCycle();

        // Write error is sticky until reset.
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 22'h80, 32'h1234_5678, 5'd0);
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        bvalid = 1'b1; bresp = 2'b10;
        nextCycle();
        bvalid = 1'b0; bresp = 2'b00;
        checkOutput("berr_set", 32'(bus_err), 32'd1);
        for (int k = 0; k < 3; k++) nextCycle();
        checkOutput("berr_sticky", 32'(bus_err), 32'd1);

        // Reset with a store buffered and a load waiting on read data.
        awready = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 22'h50, 32'h5555_5555, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 22'h30, 32'h0, 5'd6);
        checkOutput("rst_ld_ready", 32'(req_ready), 32'd1);
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        checkOutput("rst_in_lr", 32'(rready), 32'd1);
        rst = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        nextCycle();
        rst = 1'b0; rvalid = 1'b0; awready = 1'b1;
        checkOutput("rstmid_rready", 32'(rready), 32'd0);
        checkOutput("rstmid_resp",   32'(resp_valid), 32'd0);
        checkOutput("rstmid_empty",  32'(sbuf_empty), 32'd1);
        checkOutput("rstmid_ready",  32'(req_ready), 32'd1);
        checkOutput("rstmid_axi",    32'({arvalid, awvalid, wvalid, bready}), 32'd0);
        checkOutput("rstmid_berr",   32'(bus_err), 32'd0);
        nextCycle();
        checkOutput("rstmid_quiet",  32'({resp_valid, awvalid}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
